mem_agu_stage: RTL and testbench
================================

MEM_AGU_STAGE -- requirements
Module: mem_agu_stage

Interface
REQ-001 Parameter DATA_W, 32, width of base, offset, store-data and address.
REQ-002 Parameter REG_W, 5, width of destination register index.
REQ-003 Parameter ERR_CNT_W, 8, width of the misalignment event counter.
REQ-004 Ports SHALL be:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept an entry this cycle
in_oper  in  1  entry is a real memory operation (0 = bubble)
in_readmem  in  1  load request
in_writemem  in  1  store request
in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
in_rega  in  DATA_W  base address
in_imedext  in  DATA_W  sign-extended offset
in_regb  in  DATA_W  store data
in_regdest  in  REG_W  destination register
in_writereg  in  1  register write-back enable
out_valid  out  1  output entry present
out_ready  in  1  downstream accepts the output entry
out_readmem, out_writemem, out_writereg  out  1 each  qualified controls
out_size  out  2  access size passed through
out_addr  out  DATA_W  computed effective address
out_regb  out  DATA_W  store data
out_regdest  out  REG_W  destination register
out_misalign  out  1  entry faulted on alignment
err_count  out  ERR_CNT_W  saturating count of misaligned entries

Function
REQ-005 Accept = in_valid & in_ready & ~flush; transfer = out_valid & out_ready.
REQ-006 in_oper=0 entries SHALL be accepted and discarded (never enqueued, no output, no count).
REQ-007 Address SHALL be in_rega + in_imedext, modulo 2^DATA_W, computed at accept.
REQ-008 Misalign SHALL be: half with addr[0]=1; word with addr[1:0]!=0; size 11 always; byte never.
REQ-009 Misaligned entries SHALL be enqueued with out_misalign=1 and readmem, writemem, writereg forced 0; address, size, regb, regdest retained.
REQ-010 Storage SHALL be a 2-entry FIFO (skid buffer); output fields SHALL come from the head entry, driven by registers.
REQ-011 in_ready SHALL be 1 when occupancy < 2; it SHALL depend only on registered state, never on out_ready.
REQ-012 Latency SHALL be one cycle: an entry accepted on edge N SHALL be visible at out_* after edge N when the FIFO was empty.
REQ-013 Simultaneous accept and transfer SHALL keep occupancy unchanged and preserve FIFO order.
REQ-014 At occupancy 2, in_ready=0; any in_valid assertion SHALL be held off with no loss or duplication.
REQ-015 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 flush SHALL empty the FIFO on that edge, outranking simultaneous accept and transfer; next cycle out_valid=0, in_ready=1.
REQ-017 err_count SHALL increment by 1 per accepted misaligned entry, saturate at all-ones, and not be cleared by flush.
REQ-018 When out_valid=0, the control outputs (out_readmem, out_writemem, out_writereg, out_misalign) SHALL be 0.

Reset
REQ-019 reset low SHALL immediately clear the FIFO and every output to 0, err_count included, and set in_ready=1 (reset state, not an output value).
REQ-020 Reset asserted mid-transfer SHALL discard all buffered entries; no entry survives reset.

Verification
REQ-021 Word load: rega=0x1000, imedext=0x0000_0004, out_ready=1 -> next cycle out_valid=1, out_addr=0x1004, out_readmem=1, out_misalign=0.
REQ-022 Wrap: rega=0xFFFF_FFFC, imedext=0x0000_0008 -> out_addr=0x0000_0004.
REQ-023 Half store at addr 0x1001 -> out_misalign=1, out_writemem=0, err_count 0->1; after 300 misaligned entries with ERR_CNT_W=8 -> err_count=0xFF.
REQ-024 Backpressure: out_ready=0, three back-to-back entries A,B,C -> A,B stored, in_ready=0, C held off; out_ready=1 -> A,B,C emitted in order, none lost.
REQ-025 flush with occupancy 2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming entry dropped, err_count unchanged.
REQ-026 in_oper=0 with in_valid=1 -> in_ready stays 1, out_valid stays 0, err_count unchanged.

Source files
------------

// File: rtl/mem_agu_stage.sv
// Memory address-generation stage: computes base+offset, flags misaligned
// accesses, and buffers results in a 2-entry skid FIFO with registered outputs.
module mem_agu_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_oper,
  input  logic                 in_readmem,
  input  logic                 in_writemem,
  input  logic [1:0]           in_size,
  input  logic [DATA_W-1:0]    in_rega,
  input  logic [DATA_W-1:0]    in_imedext,
  input  logic [DATA_W-1:0]    in_regb,
  input  logic [REG_W-1:0]     in_regdest,
  input  logic                 in_writereg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_readmem,
  output logic                 out_writemem,
  output logic                 out_writereg,
  output logic [1:0]           out_size,
  output logic [DATA_W-1:0]    out_addr,
  output logic [DATA_W-1:0]    out_regb,
  output logic [REG_W-1:0]     out_regdest,
  output logic                 out_misalign,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef struct packed {
    logic              readmem;
    logic              writemem;
    logic              writereg;
    logic              misalign;
    logic [1:0]        size;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] regb;
    logic [REG_W-1:0]  regdest;
  } entry_t;

  entry_t                head_q, head_d;
  entry_t                tail_q, tail_d;
  entry_t                new_entry;
  logic                  head_vld_q, head_vld_d;
  logic                  tail_vld_q, tail_vld_d;
  logic [ERR_CNT_W-1:0]  err_q, err_d;
  logic                  accept;
  logic                  enq;
  logic                  deq;
  logic                  misalign;
  logic [DATA_W-1:0]     addr;

  assign in_ready = ~tail_vld_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign enq      = accept & in_oper;
  assign deq      = head_vld_q & out_ready;
  assign addr     = in_rega + in_imedext;

  always_comb begin
    misalign = 1'b0;
    case (in_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Faulted entries keep their payload but must not trigger any side effect.
  always_comb begin
    new_entry.readmem  = in_readmem & ~misalign;
    new_entry.writemem = in_writemem & ~misalign;
    new_entry.writereg = in_writereg & ~misalign;
    new_entry.misalign = misalign;
    new_entry.size     = in_size;
    new_entry.addr     = addr;
    new_entry.regb     = in_regb;
    new_entry.regdest  = in_regdest;
  end

  // Empty slots are held at zero so the head register doubles as the
  // output with idle controls already low.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
    end else begin
      if (deq) begin
        head_d     = tail_q;
        head_vld_d = tail_vld_q;
        tail_d     = '0;
        tail_vld_d = 1'b0;
      end
      if (enq) begin
        if (!head_vld_d) begin
          head_d     = new_entry;
          head_vld_d = 1'b1;
        end else begin
          tail_d     = new_entry;
          tail_vld_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (enq && new_entry.misalign && (err_q != {ERR_CNT_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      err_q      <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
      err_q      <= err_d;
    end
  end

  assign out_valid    = head_vld_q;
  assign out_readmem  = head_q.readmem;
  assign out_writemem = head_q.writemem;
  assign out_writereg = head_q.writereg;
  assign out_misalign = head_q.misalign;
  assign out_size     = head_q.size;
  assign out_addr     = head_q.addr;
  assign out_regb     = head_q.regb;
  assign out_regdest  = head_q.regdest;
  assign err_count    = err_q;

endmodule

// File: tb/tb_mem_agu_stage.sv
// Directed bench for mem_agu_stage: queue scoreboard fed at accept time,
// drained by a negedge monitor that checks every output transfer.
module tb_mem_agu_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_oper = 1'b0;
  logic        in_readmem = 1'b0;
  logic        in_writemem = 1'b0;
  logic [1:0]  in_size = 2'b00;
  logic [31:0] in_rega = '0;
  logic [31:0] in_imedext = '0;
  logic [31:0] in_regb = '0;
  logic [4:0]  in_regdest = '0;
  logic        in_writereg = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_readmem, out_writemem, out_writereg, out_misalign;
  logic [1:0]  out_size;
  logic [31:0] out_addr, out_regb;
  logic [4:0]  out_regdest;
  logic [7:0]  err_count;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        wrg;
    logic        mis;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] regb;
    logic [4:0]  rg;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  logic [7:0] err_exp = '0;
  logic sender_done;

  mem_agu_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper),
    .in_readmem(in_readmem), .in_writemem(in_writemem), .in_size(in_size),
    .in_rega(in_rega), .in_imedext(in_imedext), .in_regb(in_regb),
    .in_regdest(in_regdest), .in_writereg(in_writereg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_readmem(out_readmem), .out_writemem(out_writemem),
    .out_writereg(out_writereg), .out_size(out_size), .out_addr(out_addr),
    .out_regb(out_regb), .out_regdest(out_regdest),
    .out_misalign(out_misalign), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b1;
  endfunction

  // Drives one entry and holds it until accepted; expectations are pushed on accept.
  task automatic send(input logic oper, input logic rd, input logic wr, input logic wrg,
                      input logic [1:0] sz, input logic [31:0] a, input logic [31:0] imm,
                      input logic [31:0] b, input logic [4:0] rg);
    logic rdy;
    int   cyc;
    exp_t e;
    in_valid = 1'b1; in_oper = oper; in_readmem = rd; in_writemem = wr;
    in_writereg = wrg; in_size = sz; in_rega = a; in_imedext = imm;
    in_regb = b; in_regdest = rg;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 50) begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
      #1;
      cyc++;
    end
    if (!rdy) chk("accept_timeout", 80'd0, 80'd1);
    else if (oper) begin
      e.addr = a + imm;
      e.mis  = misaligned(sz, e.addr);
      e.rd   = rd & ~e.mis;
      e.wr   = wr & ~e.mis;
      e.wrg  = wrg & ~e.mis;
      e.size = sz;
      e.regb = b;
      e.rg   = rg;
      q.push_back(e);
      if (e.mis && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    end
    $display("[TB] send oper=%0b size=%0d addr=%08h accepted=%0b", oper, sz, a + imm, rdy);
    in_valid = 1'b0;
  endtask

  exp_t obs_now, prev_obs, popped;
  logic prev_stall = 1'b0;

  always_comb begin
    obs_now = {out_readmem, out_writemem, out_writereg, out_misalign, out_size,
               out_addr, out_regb, out_regdest};
  end

  always @(negedge clock) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !flush) chk("stall_stable", obs_now, prev_obs);
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) chk("unexpected_out", 80'd1, 80'd0);
        else begin
          popped = q.pop_front();
          chk("out_entry", obs_now, popped);
          $display("[TB] out addr=%08h mis=%0b", out_addr, out_misalign);
        end
      end
      if (!out_valid)
        chk("idle_ctrl", {76'd0, out_readmem, out_writemem, out_writereg, out_misalign}, 80'd0);
      prev_stall <= out_valid && !out_ready && !flush;
      prev_obs   <= obs_now;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_empty", 80'(q.size()), 80'd0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd1);
    chk("rst_err", 80'(err_count), 80'd0);
    chk("rst_addr", 80'(out_addr), 80'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;

    // Word load, one-cycle latency
    send(1, 1, 0, 1, 2'b10, 32'h1000, 32'h4, 32'h0, 5'd3);
    chk("lat_valid", 80'(out_valid), 80'd1);
    chk("lat_addr", 80'(out_addr), 80'h1004);
    chk("lat_readmem", 80'(out_readmem), 80'd1);
    chk("lat_mis", 80'(out_misalign), 80'd0);

    // Address wrap
    send(1, 1, 0, 1, 2'b00, 32'hFFFF_FFFC, 32'h8, 32'h0, 5'd4);
    chk("wrap_addr", 80'(out_addr), 80'h4);

    // Misaligned half store
    send(1, 0, 1, 0, 2'b01, 32'h1000, 32'h1, 32'hDEAD_BEEF, 5'd0);
    chk("half_mis", 80'(out_misalign), 80'd1);
    chk("half_wr", 80'(out_writemem), 80'd0);
    chk("err_one", 80'(err_count), 80'd1);
    drain();

    // Bubble is swallowed
    send(0, 1, 0, 1, 2'b11, 32'h0, 32'h3, 32'h0, 5'd7);
    chk("bubble_ready", 80'(in_ready), 80'd1);
    chk("bubble_valid", 80'(out_valid), 80'd0);
    chk("bubble_err", 80'(err_count), 80'(err_exp));

    // Backpressure: A,B fill, C held off
    out_ready = 1'b0;
    send(1, 1, 0, 1, 2'b10, 32'h2000, 32'h0, 32'hA, 5'd1);
    send(1, 0, 1, 0, 2'b10, 32'h2000, 32'h4, 32'hB, 5'd2);
    fork
      send(1, 1, 0, 1, 2'b01, 32'h2000, 32'h8, 32'hC, 5'd3);
      begin
        repeat (3) @(posedge clock);
        #1;
        chk("bp_in_ready", 80'(in_ready), 80'd0);
        chk("bp_out_valid", 80'(out_valid), 80'd1);
        chk("bp_head", 80'(out_addr), 80'h2000);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush at occupancy 2 with a misaligned entry arriving
    out_ready = 1'b0;
    send(1, 1, 0, 1, 2'b10, 32'h3000, 32'h0, 32'h1, 5'd5);
    send(1, 1, 0, 1, 2'b10, 32'h3004, 32'h0, 32'h2, 5'd6);
    in_valid = 1'b1; in_oper = 1'b1; in_size = 2'b11; in_rega = 32'h3008; in_imedext = 32'h0;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    chk("flush_valid", 80'(out_valid), 80'd0);
    chk("flush_ready", 80'(in_ready), 80'd1);
    chk("flush_err", 80'(err_count), 80'(err_exp));
    out_ready = 1'b1;

    // Random traffic with random backpressure
    sender_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          send(1, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
               $urandom, 32'($urandom_range(0, 7)), $urandom, 5'($urandom));
        sender_done = 1'b1;
      end
      begin
        while (!sender_done) begin
          @(posedge clock); #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Counter saturation
    for (int i = 0; i < 300; i++)
      send(1, 1, 0, 1, 2'b11, 32'(i), 32'h0, 32'h0, 5'd9);
    drain();
    chk("err_sat", 80'(err_count), 80'hFF);

    // Reset while entries are buffered
    out_ready = 1'b0;
    send(1, 1, 0, 1, 2'b10, 32'h4000, 32'h0, 32'h0, 5'd1);
    send(1, 1, 0, 1, 2'b10, 32'h4004, 32'h0, 32'h0, 5'd2);
    reset = 1'b0;
    #1;
    q.delete();
    err_exp = '0;
    chk("rst2_valid", 80'(out_valid), 80'd0);
    chk("rst2_ready", 80'(in_ready), 80'd1);
    chk("rst2_err", 80'(err_count), 80'd0);
    chk("rst2_addr", 80'(out_addr), 80'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst2_nosurvive", 80'(out_valid), 80'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
